bt_tx_sched: RTL and testbench

- Transmit scheduler in front of the bluetooth UART block.
- Shares the single UART transmitter between two byte requesters using a round-robin arbiter.
- Sequences each byte: latch the data, pulse the UART `enable`, wait for `done`, then hold an inter-byte gap.
- Guards against a hung transmitter with a timeout watchdog.

---
 rtl/bt_tx_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_bt_tx_sched.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bt_tx_sched
//  Purpose  : Transmit scheduler in front of the bluetooth UART block. Shares
//             the single UART transmitter between two byte requesters with a
//             round-robin arbiter, sequences each byte (latch data, pulse
//             uart_enable, wait for uart_done, hold an inter-byte gap) and
//             aborts a hung transfer with a timeout watchdog.
//
//  Optional : `define BT_TX_SCHED_ECHO_EN to echo every received UART byte
//             back out with top priority. Without it rx_avail / rx_dout are
//             ignored and echo_ovr is tied low.
//
//  Ports    :
//    clk_in       in   1   system clock, rising edge
//    reset        in   1   synchronous, active-low reset
//    req0/data0   in   1/8 requester 0 request (held until gnt0) and byte
//    gnt0         out  1   one-cycle pulse, data0 accepted
//    req1/data1   in   1/8 requester 1 request (held until gnt1) and byte
//    gnt1         out  1   one-cycle pulse, data1 accepted
//    uart_din     out  8   byte to the UART, stable from launch to next grant
//    uart_enable  out  1   one-cycle start pulse to the UART
//    uart_busy    in   1   UART transmitting (informational, unused)
//    uart_done    in   1   UART byte-complete pulse
//    rx_avail     in   1   UART receive byte available (level)
//    rx_dout      in   8   UART received byte
//    sched_busy   out  1   high in every state except IDLE
//    err_timeout  out  1   sticky, a byte timed out
//    echo_ovr     out  1   sticky, echo buffer overwritten
//    sent_count   out  16  bytes completed with uart_done (wrapping)
//
//  Revision : 1.0  initial release
// ============================================================================
module bt_tx_sched #(
    parameter int TIMEOUT_CYCLES = 600000,
    parameter int TO_W           = 20,
    parameter int GAP_CYCLES     = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req0,
    input  logic [7:0]  data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [7:0]  data1,
    output logic        gnt1,
    output logic [7:0]  uart_din,
    output logic        uart_enable,
    input  logic        uart_busy,
    input  logic        uart_done,
    input  logic        rx_avail,
    input  logic [7:0]  rx_dout,
    output logic        sched_busy,
    output logic        err_timeout,
    output logic        echo_ovr,
    output logic [15:0] sent_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [TO_W-1:0]     r_to_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_rr_favor1;   // 1: requester 1 wins a tie

    logic                w_idle;
    logic                w_echo_pending;
    logic [7:0]          w_echo_byte;
    logic                w_grant_echo;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_grant_any;
    logic [7:0]          w_win_byte;
    logic                w_gap_last;

    // uart_busy is informational only; sequencing relies solely on uart_done.
    logic                w_unused_busy;
    assign w_unused_busy = uart_busy;

    // ------------------------------------------------------------------------
    // Echo buffer (optional)
    // ------------------------------------------------------------------------
`ifdef BT_TX_SCHED_ECHO_EN
    logic       r_rx_avail_d;
    logic       r_echo_pending;
    logic [7:0] r_echo_buf;
    logic       r_echo_ovr;
    logic       w_rx_rise;

    assign w_rx_rise      = rx_avail & ~r_rx_avail_d;
    assign w_echo_pending = r_echo_pending;
    assign w_echo_byte    = r_echo_buf;
    assign echo_ovr       = r_echo_ovr;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_rx_avail_d   <= 1'b0;
            r_echo_pending <= 1'b0;
            r_echo_buf     <= 8'h00;
            r_echo_ovr     <= 1'b0;
        end else begin
            r_rx_avail_d <= rx_avail;
            if (w_rx_rise) begin
                // A new byte always lands in the buffer and stays pending.
                // It only counts as an overwrite if the old byte was not
                // being handed to the UART on this very cycle.
                r_echo_buf     <= rx_dout;
                r_echo_pending <= 1'b1;
                if (r_echo_pending && !w_grant_echo) begin
                    r_echo_ovr <= 1'b1;
                end
            end else if (w_grant_echo) begin
                r_echo_pending <= 1'b0;
            end
        end
    end
`else
    logic w_unused_rx;
    assign w_unused_rx    = ^{rx_avail, rx_dout};
    assign w_echo_pending = 1'b0;
    assign w_echo_byte    = 8'h00;
    assign echo_ovr       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration: echo first, then round-robin between req0 and req1.
    // Requests are only looked at in IDLE, so at most one grant can fire.
    // ------------------------------------------------------------------------
    assign w_idle       = (r_state == S_IDLE);
    assign w_grant_echo = w_idle & w_echo_pending;
    assign w_grant0     = w_idle & ~w_echo_pending & req0 & (~req1 | ~r_rr_favor1);
    assign w_grant1     = w_idle & ~w_echo_pending & req1 & (~req0 |  r_rr_favor1);
    assign w_grant_any  = w_grant_echo | w_grant0 | w_grant1;

    always_comb begin
        w_win_byte = data1;
        if (w_grant_echo) begin
            w_win_byte = w_echo_byte;
        end else if (w_grant0) begin
            w_win_byte = data0;
        end
    end

    // A zero-length gap still spends the single GAP cycle before IDLE.
    assign w_gap_last = (GAP_CYCLES == 0) || (r_gap_cnt == c_GAP_LAST);

    // ------------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_rr_favor1 <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            uart_din    <= 8'h00;
            uart_enable <= 1'b0;
            sched_busy  <= 1'b0;
            err_timeout <= 1'b0;
            sent_count  <= 16'h0000;
        end else begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            uart_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        uart_din   <= w_win_byte;
                        gnt0       <= w_grant0;
                        gnt1       <= w_grant1;
                        sched_busy <= 1'b1;
                        r_state    <= S_LAUNCH;
                        // Echo grants leave the pointer where it was.
                        if (w_grant0) begin
                            r_rr_favor1 <= 1'b1;
                        end else if (w_grant1) begin
                            r_rr_favor1 <= 1'b0;
                        end
                    end
                end

                S_LAUNCH: begin
                    uart_enable <= 1'b1;
                    r_to_cnt    <= '0;
                    r_state     <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    // done is tested first so it wins over a same-cycle timeout.
                    if (uart_done) begin
                        sent_count <= sent_count + 16'd1;
                        r_gap_cnt  <= '0;
                        r_state    <= S_GAP;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        err_timeout <= 1'b1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_GAP: begin
                    if (w_gap_last) begin
                        sched_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end

                default: begin
                    sched_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bt_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bt_tx_sched
//  Purpose  : Self-checking bench for bt_tx_sched. Bytes expected on the UART
//             are queued when requests are driven and compared against
//             uart_din at every uart_enable pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bt_tx_sched;

    localparam int TIMEOUT = 50;
    localparam int TOW     = 16;
    localparam int GAP     = 4;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        req0   = 1'b0;
    logic [7:0]  data0  = 8'h00;
    logic        req1   = 1'b0;
    logic [7:0]  data1  = 8'h00;
    logic        uart_busy = 1'b0;
    logic        uart_done = 1'b0;
    logic        rx_avail  = 1'b0;
    logic [7:0]  rx_dout   = 8'h00;
    logic        gnt0, gnt1, uart_enable, sched_busy, err_timeout, echo_ovr;
    logic [7:0]  uart_din;
    logic [15:0] sent_count;

    bt_tx_sched #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_W           (TOW),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .req0        (req0),
        .data0       (data0),
        .gnt0        (gnt0),
        .req1        (req1),
        .data1       (data1),
        .gnt1        (gnt1),
        .uart_din    (uart_din),
        .uart_enable (uart_enable),
        .uart_busy   (uart_busy),
        .uart_done   (uart_done),
        .rx_avail    (rx_avail),
        .rx_dout     (rx_dout),
        .sched_busy  (sched_busy),
        .err_timeout (err_timeout),
        .echo_ovr    (echo_ovr),
        .sent_count  (sent_count)
    );

    initial forever #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];   // bytes expected at uart_enable, in order
    int         en_q[$];    // cycle of every uart_enable
    int         done_q[$];  // cycle of every uart_done pulse
    int         gnt_q[$];   // 0/1 for each gnt0/gnt1 seen

    int done_after = -1;    // cycles from uart_enable to uart_done; <0 never
    int req0_left  = 0;     // grants before requester 0 drops req0
    int req1_left  = 0;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Scoreboard on the UART side plus grant exclusivity.
    initial begin : monitor
        logic [7:0] m_exp;
        forever begin
            @(negedge clk_in);
            if (uart_enable === 1'b1) begin
                en_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL launch_unexpected: uart_din=%02h with nothing expected", uart_din);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (uart_din !== m_exp) begin
                        errors++;
                        $display("FAIL launch_byte: uart_din=%02h expected %02h", uart_din, m_exp);
                    end
                end
            end
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                checks++;
                if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
                    errors++;
                    $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b expected one-hot", gnt0, gnt1);
                end
                gnt_q.push_back(gnt1 ? 1 : 0);
            end
        end
    end

    // UART model: returns uart_done a programmable number of cycles after launch.
    initial forever begin
        @(negedge clk_in);
        if (uart_enable === 1'b1 && done_after >= 0) begin
            repeat (done_after) @(negedge clk_in);
            uart_done = 1'b1;
            done_q.push_back(cyc);
            @(negedge clk_in);
            uart_done = 1'b0;
        end
    end

    // Requesters: hold req until the programmed number of grants is reached.
    initial forever begin
        @(negedge clk_in);
        if (gnt0 === 1'b1 && req0_left > 0) begin
            req0_left--;
            if (req0_left == 0) req0 = 1'b0;
        end
        if (gnt1 === 1'b1 && req1_left > 0) begin
            req1_left--;
            if (req1_left == 0) req1 = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic wait_en(output int e);
        e = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_in);
            if (uart_enable === 1'b1) begin
                e = cyc;
                break;
            end
        end
        if (e < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_enable: no uart_enable within 400 cycles");
        end
    endtask

    task automatic wait_idle;
        bit ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_in);
            if (sched_busy === 1'b0 && !req0 && !req1 && !uart_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: scheduler still busy after 2000 cycles");
        end
        tick(1);
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({gnt0, gnt1, uart_enable} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: gnt0/gnt1/en=%b expected 000", {gnt0, gnt1, uart_enable});
        end
        checks++;
        if (sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", sched_busy);
        end
        checks++;
        if ({err_timeout, echo_ovr} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: err/ovr=%b expected 00", {err_timeout, echo_ovr});
        end
        checks++;
        if (sent_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count: got %04h expected 0000", sent_count);
        end
        checks++;
        if (uart_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_din: got %02h expected 00", uart_din);
        end
    endtask

    task automatic test_single;
        int c0;
        done_after = 10;
        data0 = 8'h55;
        exp_q.push_back(8'h55);
        req0_left = 1;
        req0 = 1'b1;
        c0 = cyc;
        tick(1);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL single_gnt: gnt0/gnt1=%b expected 10", {gnt0, gnt1});
        end
        tick(1);
        checks++;
        if (uart_enable !== 1'b1 || cyc != c0 + 2) begin
            errors++;
            $display("FAIL single_latency: en=%b at +%0d expected 1 at +2", uart_enable, cyc - c0);
        end
        tick(10);
        checks++;
        if (sent_count !== 16'd0) begin
            errors++;
            $display("FAIL single_count_early: got %0d expected 0", sent_count);
        end
        tick(1);
        checks++;
        if (sent_count !== 16'd1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_done: count=%0d err=%b expected 1 0", sent_count, err_timeout);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back;
        bit ok = 1'b0;
        do_reset();
        en_q.delete();
        done_q.delete();
        gnt_q.delete();
        done_after = 5;
        data0 = 8'hA1;
        data1 = 8'hB2;
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        req0_left = 2;
        req1_left = 2;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if (en_q.size() >= 4 && done_q.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || gnt_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: launches=%0d grants=%0d expected 4 4", en_q.size(), gnt_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gnt_q[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL b2b_gnt_order: grant %0d went to %0d expected %0d", i, gnt_q[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (en_q[i] != done_q[i-1] + GAP + 3) begin
                    errors++;
                    $display("FAIL b2b_spacing: enable %0d at +%0d after done expected +%0d",
                             i, en_q[i] - done_q[i-1], GAP + 3);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_done_at_timeout;
        int e;
        logic [15:0] s0;
        s0 = sent_count;
        done_after = TIMEOUT - 1;
        data0 = 8'h5A;
        exp_q.push_back(8'h5A);
        req0_left = 1;
        req0 = 1'b1;
        wait_en(e);
        tick(TIMEOUT);
        checks++;
        if (sent_count !== s0 + 16'd1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_vs_timeout: count=%0d err=%b expected %0d 0", sent_count, err_timeout, s0 + 16'd1);
        end
        tick(1);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_vs_timeout_late: err=%b expected 0", err_timeout);
        end
        wait_idle();
    endtask

    task automatic test_timeout;
        int e, e2;
        logic [15:0] s0;
        s0 = sent_count;
        done_after = -1;
        data0 = 8'h99;
        exp_q.push_back(8'h99);
        req0_left = 1;
        req0 = 1'b1;
        wait_en(e);
        tick(TIMEOUT - 1);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b expected 0 one cycle before limit", err_timeout);
        end
        tick(1);
        checks++;
        if (err_timeout !== 1'b1 || sent_count !== s0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: err=%b count=%0d busy=%b expected 1 %0d 1",
                     err_timeout, sent_count, sched_busy, s0);
        end
        data1 = 8'h3C;
        exp_q.push_back(8'h3C);
        req1_left = 1;
        req1 = 1'b1;
        done_after = 3;
        wait_en(e2);
        checks++;
        if (e2 != e + TIMEOUT + GAP + 2) begin
            errors++;
            $display("FAIL timeout_next_launch: at +%0d expected +%0d", e2 - e, TIMEOUT + GAP + 2);
        end
        wait_idle();
        checks++;
        if (sent_count !== s0 + 16'd1 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: count=%0d err=%b expected %0d 1", sent_count, err_timeout, s0 + 16'd1);
        end
    endtask

    task automatic test_reset_abort;
        int e;
        done_after = -1;
        data0 = 8'h42;
        exp_q.push_back(8'h42);
        req0_left = 1;
        req0 = 1'b1;
        wait_en(e);
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        checks++;
        if ({sched_busy, err_timeout, gnt0, gnt1, uart_enable} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_flags: busy/err/g0/g1/en=%b expected 00000",
                     {sched_busy, err_timeout, gnt0, gnt1, uart_enable});
        end
        checks++;
        if (sent_count !== 16'd0 || uart_din !== 8'h00) begin
            errors++;
            $display("FAIL abort_regs: count=%0d din=%02h expected 0 00", sent_count, uart_din);
        end
        tick(2);
        uart_done = 1'b1;
        tick(1);
        uart_done = 1'b0;
        tick(3);
        checks++;
        if (sent_count !== 16'd0 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stray_done: count=%0d busy=%b expected 0 0", sent_count, sched_busy);
        end
    endtask

`ifdef BT_TX_SCHED_ECHO_EN
    task automatic test_echo;
        int e;
        do_reset();
        done_after = 6;
        data1 = 8'h10;
        exp_q.push_back(8'h10);
        req1_left = 1;
        req1 = 1'b1;
        wait_en(e);
        // While 0x10 is in flight: requester 0 and a received byte both arrive.
        data0 = 8'hC3;
        req0_left = 1;
        req0 = 1'b1;
        rx_dout = 8'h7E;
        rx_avail = 1'b1;
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'hC3);
        tick(1);
        rx_avail = 1'b0;
        wait_en(e);
        wait_en(e);
        wait_idle();
        checks++;
        if (echo_ovr !== 1'b0) begin
            errors++;
            $display("FAIL echo_no_ovr: got %b expected 0", echo_ovr);
        end
        data1 = 8'h20;
        exp_q.push_back(8'h20);
        req1_left = 1;
        req1 = 1'b1;
        wait_en(e);
        tick(1);
        rx_dout = 8'h11;
        rx_avail = 1'b1;
        tick(1);
        rx_avail = 1'b0;
        tick(1);
        rx_dout = 8'h22;
        rx_avail = 1'b1;
        exp_q.push_back(8'h22);
        tick(1);
        rx_avail = 1'b0;
        wait_en(e);
        wait_idle();
        checks++;
        if (echo_ovr !== 1'b1) begin
            errors++;
            $display("FAIL echo_ovr: got %b expected 1", echo_ovr);
        end
    endtask
`else
    task automatic test_echo;
        do_reset();
        rx_dout = 8'h7E;
        rx_avail = 1'b1;
        tick(2);
        rx_avail = 1'b0;
        tick(2);
        rx_dout = 8'h22;
        rx_avail = 1'b1;
        tick(2);
        rx_avail = 1'b0;
        tick(4);
        checks++;
        if (echo_ovr !== 1'b0 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_ignored: ovr=%b busy=%b expected 0 0", echo_ovr, sched_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_done_at_timeout();
        test_timeout();
        test_reset_abort();
        test_echo();
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes never launched expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
